// File: rtl/dyna85_sequencer.sv
// Dyna-85 multi-cycle instruction sequencer: fetch, decode, operand capture and
// execute control for the MOV/MVI/JMP/Jcc/LDA/STA/NOP/HLT subset, with a memory-ready timeout.
module dyna85_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        opcode_i,
    input  logic [3:0]        flags_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ready_i,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic              addr_sel_o,
    output logic [ADDR_W-1:0] operand_addr_o,
    output logic              ir_load_o,
    output logic              pc_inc_o,
    output logic              pc_load_o,
    output logic              reg_we_o,
    output logic [2:0]        reg_read_sel_o,
    output logic [2:0]        reg_write_sel_o,
    output logic [1:0]        data_path_sel_o,
    output logic              illegal_op_o,
    output logic              bus_err_o,
    output logic              halted_o,
    output logic [3:0]        state_debug_o
);

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_OPLO   = 4'd2,
        ST_OPHI   = 4'd3,
        ST_MOV_EX = 4'd4,
        ST_JMP_EX = 4'd5,
        ST_LDA_RD = 4'd6,
        ST_STA_WR = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    localparam int HI_W   = ADDR_W - DATA_W;
    localparam bit TMO_EN = (MEM_TIMEOUT != 0);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] opr_lo_q, opr_lo_d;
    logic [HI_W-1:0]   opr_hi_q, opr_hi_d;
    logic [TMO_W-1:0]  wait_q, wait_d;

    // The IR is held externally until the next fetch, so later states decode it directly.
    logic is_hlt, is_nop, is_mov, is_mvi, is_jmp, is_jcc, is_lda, is_sta;
    logic cond_true, mem_state, timeout;

    assign is_hlt = (opcode_i == 8'h76);
    assign is_nop = (opcode_i == 8'h00);
    assign is_mov = (opcode_i[7:6] == 2'b01) && !is_hlt;
    assign is_mvi = (opcode_i[7:6] == 2'b00) && (opcode_i[2:0] == 3'b110);
    assign is_jmp = (opcode_i == 8'hC3);
    assign is_jcc = (opcode_i[7:6] == 2'b11) && (opcode_i[2:0] == 3'b010);
    assign is_lda = (opcode_i == 8'h3A);
    assign is_sta = (opcode_i == 8'h32);

    always_comb begin
        case (opcode_i[5:3])
            3'b000:  cond_true = !flags_i[2];
            3'b001:  cond_true =  flags_i[2];
            3'b010:  cond_true = !flags_i[0];
            3'b011:  cond_true =  flags_i[0];
            3'b100:  cond_true = !flags_i[1];
            3'b101:  cond_true =  flags_i[1];
            3'b110:  cond_true = !flags_i[3];
            default: cond_true =  flags_i[3];
        endcase
    end

    assign mem_state = (state_q == ST_FETCH) || (state_q == ST_OPLO) || (state_q == ST_OPHI) ||
                       (state_q == ST_LDA_RD) || (state_q == ST_STA_WR);
    assign timeout   = TMO_EN && mem_state && (wait_q == TMO_W'(MEM_TIMEOUT));

    assign operand_addr_o = {opr_hi_q, opr_lo_q};
    assign state_debug_o  = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            opr_lo_q <= '0;
            opr_hi_q <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            opr_lo_q <= opr_lo_d;
            opr_hi_q <= opr_hi_d;
            wait_q   <= wait_d;
        end
    end

    // Every control output stays at its default of 0 while reset is high.
    always_comb begin
        state_d         = state_q;
        wait_d          = '0;
        opr_lo_d        = opr_lo_q;
        opr_hi_d        = opr_hi_q;
        mem_rd_o        = 1'b0;
        mem_wr_o        = 1'b0;
        addr_sel_o      = 1'b0;
        ir_load_o       = 1'b0;
        pc_inc_o        = 1'b0;
        pc_load_o       = 1'b0;
        reg_we_o        = 1'b0;
        reg_read_sel_o  = 3'b000;
        reg_write_sel_o = 3'b000;
        data_path_sel_o = 2'd0;
        illegal_op_o    = 1'b0;
        bus_err_o       = 1'b0;
        halted_o        = 1'b0;
        if (!reset) begin
            if (timeout) begin
                bus_err_o = 1'b1;
                state_d   = ST_HALT;
            end else begin
                case (state_q)
                    ST_FETCH: begin
                        mem_rd_o = 1'b1;
                        if (mem_ready_i) begin
                            ir_load_o = 1'b1;
                            pc_inc_o  = 1'b1;
                            state_d   = ST_DECODE;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                    ST_DECODE: begin
                        if (is_hlt) begin
                            state_d = ST_HALT;
                        end else if (is_nop) begin
                            state_d = ST_FETCH;
                        end else if (is_mov) begin
                            reg_read_sel_o  = opcode_i[2:0];
                            reg_write_sel_o = opcode_i[5:3];
                            data_path_sel_o = 2'd1;
                            state_d         = ST_MOV_EX;
                        end else if (is_mvi || is_jmp || is_jcc || is_lda || is_sta) begin
                            state_d = ST_OPLO;
                        end else begin
                            illegal_op_o = 1'b1;
                            state_d      = ST_FETCH;
                        end
                    end
                    ST_MOV_EX: begin
                        reg_we_o        = 1'b1;
                        reg_read_sel_o  = opcode_i[2:0];
                        reg_write_sel_o = opcode_i[5:3];
                        data_path_sel_o = 2'd1;
                        state_d         = ST_FETCH;
                    end
                    ST_OPLO: begin
                        mem_rd_o = 1'b1;
                        if (mem_ready_i) begin
                            pc_inc_o = 1'b1;
                            if (is_mvi) begin
                                reg_we_o        = 1'b1;
                                reg_write_sel_o = opcode_i[5:3];
                                data_path_sel_o = 2'd2;
                                state_d         = ST_FETCH;
                            end else begin
                                opr_lo_d = mem_data_i;
                                state_d  = ST_OPHI;
                            end
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                    ST_OPHI: begin
                        mem_rd_o = 1'b1;
                        if (mem_ready_i) begin
                            pc_inc_o = 1'b1;
                            opr_hi_d = HI_W'(mem_data_i);
                            if (is_lda)      state_d = ST_LDA_RD;
                            else if (is_sta) state_d = ST_STA_WR;
                            else             state_d = ST_JMP_EX;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                    ST_JMP_EX: begin
                        pc_load_o = is_jmp || cond_true;
                        state_d   = ST_FETCH;
                    end
                    ST_LDA_RD: begin
                        mem_rd_o   = 1'b1;
                        addr_sel_o = 1'b1;
                        if (mem_ready_i) begin
                            reg_we_o        = 1'b1;
                            reg_write_sel_o = 3'b111;
                            data_path_sel_o = 2'd2;
                            state_d         = ST_FETCH;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                    ST_STA_WR: begin
                        mem_wr_o        = 1'b1;
                        addr_sel_o      = 1'b1;
                        reg_read_sel_o  = 3'b111;
                        data_path_sel_o = 2'd1;
                        if (mem_ready_i) state_d = ST_FETCH;
                        else             wait_d  = wait_q + 1'b1;
                    end
                    ST_HALT: begin
                        halted_o = 1'b1;
                    end
                    default: begin
                        state_d = ST_FETCH;
                    end
                endcase
            end
        end
    end

endmodule
